// File: rtl/m_phy_rx_mode_ctrl_if.sv
// m_phy_rx_mode_ctrl_if: command handshake, PHY status and transition strobes of the RX mode controller
interface m_phy_rx_mode_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        burst_end;
  logic [1:0]  phy_state;
  logic        pwm_2_sleep;
  logic        pwm_2_line_cfg;
  logic        line_cfg_2_sleep;
  logic        line_cfg_2_stall;
  logic        hs_2_stall;
  logic        hs_2_line_cfg;
  logic        rct;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] burst_cycles;
  modport master (
    output cmd_valid, cmd_op, burst_end, phy_state,
    input  cmd_ready, pwm_2_sleep, pwm_2_line_cfg, line_cfg_2_sleep, line_cfg_2_stall,
           hs_2_stall, hs_2_line_cfg, rct, busy, done, err, burst_cycles
  );
  modport slave (
    input  cmd_valid, cmd_op, burst_end, phy_state,
    output cmd_ready, pwm_2_sleep, pwm_2_line_cfg, line_cfg_2_sleep, line_cfg_2_stall,
           hs_2_stall, hs_2_line_cfg, rct, busy, done, err, burst_cycles
  );
endinterface

// File: rtl/m_phy_rx_mode_ctrl.sv
// m_phy_rx_mode_ctrl: turns mode commands into one-cycle RX transition strobes, tracks ack and burst length
module m_phy_rx_mode_ctrl #(
  parameter int ACK_TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 reset,
  m_phy_rx_mode_ctrl_if.slave rx
);
  localparam logic [1:0] S_IDLE = 2'd0, S_HOLD = 2'd1, S_STROBE = 2'd2, S_WAIT_ACK = 2'd3;
  localparam logic [1:0] OP_SLEEP = 2'd0, OP_STALL = 2'd1, OP_HIBERN8 = 2'd2, OP_LINE_CFG = 2'd3;
  localparam logic [1:0] PS_OTHER = 2'd0, PS_PWM = 2'd1, PS_LCFG = 2'd2, PS_HS = 2'd3;
  localparam logic [6:0] ST_PWM_SLEEP = 7'h01, ST_PWM_LCFG = 7'h02, ST_LCFG_SLEEP = 7'h04,
                         ST_LCFG_STALL = 7'h08, ST_HS_STALL = 7'h10, ST_HS_LCFG = 7'h20,
                         ST_RCT = 7'h40;
  logic [1:0]  state_q, state_d, op_q, op_d, src_q, src_d, ps_q;
  logic [6:0]  strb_q, strb_d, sel;
  logic        done_q, done_d, err_q, err_d, seen_q, seen_d;
  logic        bad, cfg_done, go, in_burst, leave;
  logic [15:0] ack_q, ack_d, bcnt_q, bcnt_d, blen_q, blen_d;
  assign in_burst = rx.phy_state[0];
  // Legal transitions depend on where the RX machine currently is.
  always_comb begin
    sel      = '0;
    bad      = 1'b0;
    cfg_done = 1'b0;
    case (rx.phy_state)
      PS_PWM: begin
        sel = op_q == OP_SLEEP ? ST_PWM_SLEEP : op_q == OP_LINE_CFG ? ST_PWM_LCFG : 7'h00;
        bad = op_q == OP_STALL || op_q == OP_HIBERN8;
      end
      PS_HS: begin
        sel = op_q == OP_STALL ? ST_HS_STALL : op_q == OP_LINE_CFG ? ST_HS_LCFG : 7'h00;
        bad = op_q == OP_SLEEP || op_q == OP_HIBERN8;
      end
      PS_LCFG: begin
        sel = op_q == OP_SLEEP ? ST_LCFG_SLEEP : op_q == OP_STALL ? ST_LCFG_STALL :
              op_q == OP_HIBERN8 ? ST_RCT : 7'h00;
        cfg_done = op_q == OP_LINE_CFG;
      end
      default: sel = op_q == OP_HIBERN8 ? ST_RCT : 7'h00;
    endcase
  end
  // Inside a burst a transition may only be issued once the burst has ended.
  assign go = sel != 7'h00 && (!in_burst || seen_q);
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    strb_d  = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ack_d   = ack_q;
    case (state_q)
      S_IDLE: begin
        op_d    = rx.cmd_valid ? rx.cmd_op : op_q;
        state_d = rx.cmd_valid ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (bad) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cfg_done) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (go) begin
          strb_d  = sel;
          src_d   = rx.phy_state;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        ack_d   = '0;
        done_d  = src_q == PS_OTHER;
        state_d = src_q == PS_OTHER ? S_IDLE : S_WAIT_ACK;
      end
      default: begin
        if (rx.phy_state != src_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (ack_q == 16'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          ack_d = ack_q + 16'd1;
        end
      end
    endcase
  end
  assign seen_d = (state_q == S_HOLD && !bad && !cfg_done && go) ? 1'b0 :
                  !in_burst ? 1'b0 : (rx.burst_end ? 1'b1 : seen_q);
  // A burst ends whenever the state leaves a burst code, including a PWM<->HS switch.
  assign leave  = ps_q[0] && rx.phy_state != ps_q;
  assign blen_d = leave ? bcnt_q : blen_q;
  assign bcnt_d = leave ? {15'd0, in_burst} :
                  in_burst ? (bcnt_q == 16'hFFFF ? bcnt_q : bcnt_q + 16'd1) : 16'd0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      src_q   <= '0;
      ps_q    <= '0;
      strb_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
      ack_q   <= '0;
      bcnt_q  <= '0;
      blen_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      ps_q    <= rx.phy_state;
      strb_q  <= strb_d;
      done_q  <= done_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      ack_q   <= ack_d;
      bcnt_q  <= bcnt_d;
      blen_q  <= blen_d;
    end
  end
  assign rx.cmd_ready        = state_q == S_IDLE;
  assign rx.busy             = state_q != S_IDLE;
  assign rx.done             = done_q;
  assign rx.err              = err_q;
  assign rx.burst_cycles     = blen_q;
  assign rx.pwm_2_sleep      = strb_q[0];
  assign rx.pwm_2_line_cfg   = strb_q[1];
  assign rx.line_cfg_2_sleep = strb_q[2];
  assign rx.line_cfg_2_stall = strb_q[3];
  assign rx.hs_2_stall       = strb_q[4];
  assign rx.hs_2_line_cfg    = strb_q[5];
  assign rx.rct              = strb_q[6];
endmodule

// File: doc/m_phy_rx_mode_ctrl.md
M_PHY_RX_MODE_CTRL -- requirements
Module: m_phy_rx_mode_ctrl

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 64, max cycles in WAIT_ACK before error.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_op  input  2  target: 0 SLEEP, 1 STALL, 2 HIBERN8, 3 LINE_CFG.
REQ-007 SHALL have port burst_end  input  1  one-cycle end-of-burst marker from deserializer.
REQ-008 SHALL have port phy_state  input  2  RX state code: 00 other/idle, 01 PWM_BURST, 10 LINE_CFG, 11 HS_BURST.
REQ-009 SHALL have ports pwm_2_sleep, pwm_2_line_cfg, line_cfg_2_sleep, line_cfg_2_stall, hs_2_stall, hs_2_line_cfg, rct  output  1 each  transition strobes to RX state machine.
REQ-010 SHALL have port busy  output  1  high whenever FSM not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse on command completion.
REQ-012 SHALL have port err  output  1  one-cycle pulse on illegal command or ack timeout.
REQ-013 SHALL have port burst_cycles  output  16  length in cycles of last completed burst.

Function
REQ-014 SHALL implement FSM states IDLE, HOLD, STROBE, WAIT_ACK.
REQ-015 IDLE: cmd_ready=1; on cmd_valid, latch cmd_op, go HOLD; cmd_ready=0 in all other states.
REQ-016 HOLD, phy_state 01: op SLEEP -> pwm_2_sleep, LINE_CFG -> pwm_2_line_cfg; STALL/HIBERN8 -> err, IDLE.
REQ-017 HOLD, phy_state 11: op STALL -> hs_2_stall, LINE_CFG -> hs_2_line_cfg; SLEEP/HIBERN8 -> err, IDLE.
REQ-018 HOLD, phy_state 10: SLEEP -> line_cfg_2_sleep, STALL -> line_cfg_2_stall, HIBERN8 -> rct; LINE_CFG -> done, IDLE, no strobe.
REQ-019 HOLD, phy_state 00: HIBERN8 -> rct; other ops wait in HOLD with no timeout.
REQ-020 From phy_state 01/11, strobe SHALL wait until burst_end_seen is set; from 10/00, strobe selected immediately.
REQ-021 burst_end_seen SHALL set on burst_end while phy_state is 01 or 11 in any FSM state, clear on strobe issue or when phy_state is 00/10.
REQ-022 On strobe selection, FSM SHALL capture source phy_state and enter STROBE; STROBE lasts exactly one cycle, exactly one strobe output high.
REQ-023 Strobe outputs SHALL be registered and zero in every cycle other than STROBE.
REQ-024 After STROBE with source 00: done pulse, IDLE next cycle (no observable ack).
REQ-025 After STROBE with other source: enter WAIT_ACK, clear ack counter.
REQ-026 WAIT_ACK: phy_state != captured source -> done pulse, IDLE; ack counter reaching ACK_TIMEOUT-1 -> err pulse, IDLE.
REQ-027 Ack and phy_state change in same cycle as timeout SHALL be reported as done, not err.
REQ-028 Burst counter SHALL increment each cycle phy_state is 01 or 11, saturating at 16'hFFFF.
REQ-029 On phy_state leaving 01/11 (including 01<->11 change), burst_cycles SHALL load counter value and counter SHALL restart at 0 (1 if new state is a burst).
REQ-030 busy SHALL be combinational (state != IDLE); done/err registered, never high together.

Reset
REQ-031 reset low SHALL asynchronously force IDLE, all strobes 0, done 0, err 0, burst_end_seen 0, counters 0, burst_cycles 0.
REQ-032 Reset asserted mid-command SHALL abort it with no strobe, done or err emitted after release.
REQ-033 First command SHALL be acceptable on first clock edge after reset deasserts.

Verification
REQ-034 phy_state=01, cmd SLEEP, burst_end 5 cycles later -> pwm_2_sleep one cycle after burst_end sampled; phy_state->00 -> done; burst_cycles = cycles spent in 01.
REQ-035 phy_state=10, cmd HIBERN8 -> rct pulse 2 cycles after accept; phy_state->00 -> done, busy low.
REQ-036 phy_state=11, cmd SLEEP -> err pulse, no strobe, cmd_ready high next cycle.
REQ-037 phy_state=10, cmd STALL, phy_state held 10 -> line_cfg_2_stall, err exactly ACK_TIMEOUT cycles after WAIT_ACK entry (64).
REQ-038 phy_state=00, cmd STALL; 10 cycles later phy_state=11, burst_end -> hs_2_stall; reset pulsed low mid-WAIT_ACK -> all outputs 0, IDLE.
REQ-039 phy_state held 01 for 70000 cycles then 00 -> burst_cycles = 16'hFFFF.
